// File: rtl/nextasic_receiver.sv
// Deserialises 41-bit NeXT serial frames (start bit + 40 payload bits, MSB first),
// steering audio frames to a strobe port and others into a one-entry valid/ready holding register.
// Optional 2-flop input synchroniser: define NEXTASIC_RX_SYNC_EN.
module nextasic_receiver #(
  parameter logic [7:0]  AUDIO_CMD = 8'hC7,
  parameter int unsigned GAP_BITS  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [39:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] audio_data,
  output logic        audio_valid,
  output logic        overrun,
  output logic        frame_error
);

  localparam int unsigned CNT_W     = 6;
  localparam int unsigned PAYLOAD_W = 40;
  localparam int unsigned AUDIO_W   = 32;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);

  typedef enum logic [1:0] {IDLE, RECV, GAP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] shift_q, shift_d;
  logic                 done_q, done_c;
  logic                 ferr_c;
  logic                 s;

`ifdef NEXTASIC_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchroniser for an asynchronous serial line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], sin};
  end
  assign s = sync_q[1];
`else
  assign s = sin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      done_q  <= done_c;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_c  = 1'b0;
    ferr_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        shift_d = {shift_q[PAYLOAD_W-2:0], s};
        if (cnt_q == LAST_BIT) begin
          done_c  = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_BITS == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        // A 1 here is flagged but never taken as a start bit
        ferr_c = s;
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame dispatch, holding register and status pulses; shift_q is stable during the dispatch cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      audio_data  <= '0;
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= ferr_c;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (done_q) begin
        if (shift_q[PAYLOAD_W-1:AUDIO_W] == AUDIO_CMD) begin
          audio_data  <= shift_q[AUDIO_W-1:0];
          audio_valid <= 1'b1;
        end else if (!out_valid || out_ready) begin
          out_data  <= shift_q;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
